// File: rtl/theta_pkg.sv
// Shared theta definitions: page geometry, controller state codes
// and mod-5 lane index helpers.
package theta_pkg;

  localparam int PAGE_W = 25;
  localparam int LANES  = 5;

  typedef logic [0:PAGE_W-1] page_t;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_PREV = 3'd1;
  localparam logic [2:0] S_WT_PREV = 3'd2;
  localparam logic [2:0] S_LD_CUR  = 3'd3;
  localparam logic [2:0] S_WT_CUR  = 3'd4;
  localparam logic [2:0] S_SCAN    = 3'd5;
  localparam logic [2:0] S_WRITE   = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  function automatic logic [2:0] inc5(input logic [2:0] v);
    return (v >= 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  function automatic logic [2:0] dec5(input logic [2:0] v);
    return (v == 3'd0) ? 3'd4 : v - 3'd1;
  endfunction

endpackage

// File: rtl/theta_lane_counter.sv
// Walks (x,y) over the 5x5 lane grid, y fastest, with explicit
// wrap at 5 and mod-5 column neighbours.
module theta_lane_counter
  import theta_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       step,
  output logic [2:0] x_cur,
  output logic [2:0] y_cur,
  output logic [2:0] x_prev,
  output logic [2:0] x_next,
  output logic       last
);

  logic [2:0] x_q, x_d;
  logic [2:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = 3'd0;
      y_d = 3'd0;
    end else if (step) begin
      if (y_q == 3'd4) begin
        y_d = 3'd0;
        x_d = inc5(x_q);
      end else begin
        y_d = inc5(y_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= 3'd0;
      y_q <= 3'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_cur  = x_q;
  assign y_cur  = y_q;
  assign x_prev = dec5(x_q);
  assign x_next = inc5(x_q);
  assign last   = (x_q == 3'd4) && (y_q == 3'd4);

endmodule

// File: rtl/parity_controller.sv
// Sequences the theta parity datapath over all z-pages of a state:
// fetch prev/cur pages, scan the 25 lanes, write the result page.
module parity_controller
  import theta_pkg::*;
#(
  parameter int PAGES  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [0:24]       rd_data,
  output logic [0:24]       cur_page,
  output logic [0:24]       prev_page,
  output logic [2:0]        x_prev,
  output logic [2:0]        x_cur,
  output logic [2:0]        x_next,
  output logic [2:0]        y_cur,
  input  logic [0:24]       parity_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [0:24]       wr_data
);

  localparam logic [ADDR_W-1:0] LAST_Z = ADDR_W'(PAGES - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] z_q, z_d;
  page_t             cur_q, cur_d;
  page_t             prev_q, prev_d;
  logic              lane_clear, lane_step, lane_last;

  always_comb begin
    state_d    = state_q;
    z_d        = z_q;
    cur_d      = cur_q;
    prev_d     = prev_q;
    lane_clear = 1'b0;
    lane_step  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LD_PREV;
          z_d     = '0;
        end
      end
      S_LD_PREV: state_d = S_WT_PREV;
      S_WT_PREV: begin
        prev_d  = rd_data;
        state_d = S_LD_CUR;
      end
      S_LD_CUR: state_d = S_WT_CUR;
      S_WT_CUR: begin
        cur_d      = rd_data;
        lane_clear = 1'b1;
        state_d    = S_SCAN;
      end
      S_SCAN: begin
        lane_step = 1'b1;
        if (lane_last) state_d = S_WRITE;
      end
      S_WRITE: begin
        // this page becomes the z-1 neighbour of the next one
        prev_d = cur_q;
        if (z_q == LAST_Z) begin
          state_d = S_DONE;
        end else begin
          z_d     = z_q + 1'b1;
          state_d = S_LD_CUR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      z_q     <= '0;
      cur_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
    end
  end

  theta_lane_counter u_lanes (
    .clk    (clk),
    .rst    (rst),
    .clear  (lane_clear),
    .step   (lane_step),
    .x_cur  (x_cur),
    .y_cur  (y_cur),
    .x_prev (x_prev),
    .x_next (x_next),
    .last   (lane_last)
  );

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rd_en     = (state_q == S_LD_PREV) || (state_q == S_LD_CUR);
  assign rd_addr   = (state_q == S_LD_PREV) ? LAST_Z :
                     (state_q == S_LD_CUR)  ? z_q : '0;
  assign wr_en     = (state_q == S_WRITE);
  assign wr_addr   = wr_en ? z_q : '0;
  assign wr_data   = wr_en ? parity_out : '0;
  assign cur_page  = cur_q;
  assign prev_page = prev_q;

endmodule
